// File: rtl/merc16_register_file.sv
// MERC-16 general-purpose register file: 16 x 16-bit, R0 hardwired to zero.
// Five combinational read ports (two full-address, three short-address reaching R0..R7)
// and one synchronous write port driven by writeback.
// Optional feature: define WRITE_BYPASS_EN to forward same-cycle write data to any
// read port whose (zero-extended) address matches a live, non-R0 write.
module merc16_register_file #(
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned ADDR_WIDTH       = 4,
    parameter int unsigned SHORT_ADDR_WIDTH = 3
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [ADDR_WIDTH-1:0]       RsAddr,
    input  logic [SHORT_ADDR_WIDTH-1:0] RsShortAddr,
    input  logic [SHORT_ADDR_WIDTH-1:0] RtAddr,
    input  logic [ADDR_WIDTH-1:0]       RdAddr,
    input  logic [SHORT_ADDR_WIDTH-1:0] RdShortAddr,
    input  logic [ADDR_WIDTH-1:0]       WriteAddr,
    input  logic [DATA_WIDTH-1:0]       WriteData,
    input  logic                        WriteEnable,
    output logic [DATA_WIDTH-1:0]       Rs,
    output logic [DATA_WIDTH-1:0]       RsShort,
    output logic [DATA_WIDTH-1:0]       Rt,
    output logic [DATA_WIDTH-1:0]       Rd,
    output logic [DATA_WIDTH-1:0]       RdShort
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int unsigned PAD      = ADDR_WIDTH - SHORT_ADDR_WIDTH;

    // Only R1..R(NUM_REGS-1) are stored; R0 is synthesised as a constant in the read view.
    logic [DATA_WIDTH-1:0] regQ    [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] regView [NUM_REGS];

    logic [ADDR_WIDTH-1:0] rsShortExt;
    logic [ADDR_WIDTH-1:0] rtExt;
    logic [ADDR_WIDTH-1:0] rdShortExt;
    logic                  writeHit;

    // Short addresses are zero-extended so they can never reach the upper half.
    assign rsShortExt = {{PAD{1'b0}}, RsShortAddr};
    assign rtExt      = {{PAD{1'b0}}, RtAddr};
    assign rdShortExt = {{PAD{1'b0}}, RdShortAddr};

    // Writes to R0 are dropped here so R0 never needs storage.
    assign writeHit = WriteEnable && (WriteAddr != '0);

    // Register storage: async clear, single synchronous write port.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regQ[i] <= '0;
            end
        end else if (writeHit) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (WriteAddr == i[ADDR_WIDTH-1:0]) begin
                    regQ[i] <= WriteData;
                end
            end
        end
    end

    // Full 2**ADDR_WIDTH-entry read view with R0 fixed at zero; no undefined entries.
    always_comb begin
        regView[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            regView[i] = regQ[i];
        end
    end

`ifdef WRITE_BYPASS_EN
    logic bypassLive;

    // Forwarding only applies to a write that will actually land this edge.
    assign bypassLive = writeHit && Reset;

    // Read ports with same-cycle write forwarding.
    always_comb begin
        Rs      = regView[RsAddr];
        RsShort = regView[rsShortExt];
        Rt      = regView[rtExt];
        Rd      = regView[RdAddr];
        RdShort = regView[rdShortExt];
        if (bypassLive && (RsAddr == WriteAddr))     Rs      = WriteData;
        if (bypassLive && (rsShortExt == WriteAddr)) RsShort = WriteData;
        if (bypassLive && (rtExt == WriteAddr))      Rt      = WriteData;
        if (bypassLive && (RdAddr == WriteAddr))     Rd      = WriteData;
        if (bypassLive && (rdShortExt == WriteAddr)) RdShort = WriteData;
    end
`else
    // Read ports show registered contents only.
    always_comb begin
        Rs      = regView[RsAddr];
        RsShort = regView[rsShortExt];
        Rt      = regView[rtExt];
        Rd      = regView[RdAddr];
        RdShort = regView[rdShortExt];
    end
`endif

endmodule

// File: tb/tb_merc16_register_file.sv
// Self-checking bench for merc16_register_file: directed scenarios plus randomized
// traffic checked against an array-based reference model of the register file.
module tb_merc16_register_file;

    logic        Clock;
    logic        Reset;
    logic [3:0]  RsAddr;
    logic [2:0]  RsShortAddr;
    logic [2:0]  RtAddr;
    logic [3:0]  RdAddr;
    logic [2:0]  RdShortAddr;
    logic [3:0]  WriteAddr;
    logic [15:0] WriteData;
    logic        WriteEnable;
    logic [15:0] Rs;
    logic [15:0] RsShort;
    logic [15:0] Rt;
    logic [15:0] Rd;
    logic [15:0] RdShort;

    int nChecks = 0;
    int nPass   = 0;

    // Reference model: plain array of register contents, index 0 unused.
    logic [15:0] model [16];

    merc16_register_file dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .RsAddr      (RsAddr),
        .RsShortAddr (RsShortAddr),
        .RtAddr      (RtAddr),
        .RdAddr      (RdAddr),
        .RdShortAddr (RdShortAddr),
        .WriteAddr   (WriteAddr),
        .WriteData   (WriteData),
        .WriteEnable (WriteEnable),
        .Rs          (Rs),
        .RsShort     (RsShort),
        .Rt          (Rt),
        .Rd          (Rd),
        .RdShort     (RdShort)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkValue(input string tag, input logic [15:0] actual,
                              input logic [15:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [15:0] expRead(input logic [3:0] addr);
        if (addr == 4'd0) return 16'h0000;
`ifdef WRITE_BYPASS_EN
        if (Reset && WriteEnable && (WriteAddr != 4'd0) && (WriteAddr == addr))
            return WriteData;
`endif
        return model[addr];
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    endtask

    // One rising edge; model takes the write seen at the edge, then settle 1 time unit.
    task automatic tick();
        @(posedge Clock);
        if (Reset && WriteEnable && (WriteAddr != 4'd0)) model[WriteAddr] = WriteData;
        #1;
    endtask

    task automatic setAddrs(input logic [3:0] full, input logic [2:0] sh);
        RsAddr      = full;
        RdAddr      = full;
        RsShortAddr = sh;
        RtAddr      = sh;
        RdShortAddr = sh;
    endtask

    task automatic checkAll(input string tag);
        checkValue({tag, "_rs"},      Rs,      expRead(RsAddr));
        checkValue({tag, "_rsshort"}, RsShort, expRead({1'b0, RsShortAddr}));
        checkValue({tag, "_rt"},      Rt,      expRead({1'b0, RtAddr}));
        checkValue({tag, "_rd"},      Rd,      expRead(RdAddr));
        checkValue({tag, "_rdshort"}, RdShort, expRead({1'b0, RdShortAddr}));
    endtask

    initial begin
        logic [3:0]  a4;
        logic [15:0] oldVal;

        Reset       = 1'b0;
        WriteEnable = 1'b0;
        WriteAddr   = 4'd0;
        WriteData   = 16'hA5A5;
        setAddrs(4'd0, 3'd0);
        clearModel();

        // 1: reset then idle clocks, everything reads zero.
        #12;
        Reset = 1'b1;
        tick();
        tick();
        checkAll("reset");

        // 2: fill R1..R7 through all ports.
        WriteEnable = 1'b1;
        for (int i = 1; i < 8; i++) begin
            a4 = 4'(i);
            setAddrs(a4, a4[2:0]);
            WriteAddr = a4;
            WriteData = 16'(i);
            tick();
            tick();
            checkValue("low_rs",      Rs,      16'(i));
            checkValue("low_rsshort", RsShort, 16'(i));
            checkValue("low_rt",      Rt,      16'(i));
            checkValue("low_rdshort", RdShort, 16'(i));
        end

        // 3: fill R8..R15; short ports alias down to R0..R7.
        for (int i = 8; i < 16; i++) begin
            a4 = 4'(i);
            setAddrs(a4, a4[2:0]);
            WriteAddr = a4;
            WriteData = 16'(i);
            tick();
            tick();
            checkValue("high_rs", Rs, 16'(i));
            checkValue("high_rd", Rd, 16'(i));
            checkValue("high_rt", Rt, 16'(i - 8));
            checkValue("high_rdshort", RdShort, 16'(i - 8));
        end

        // 4: write disabled sweep, contents unchanged.
        WriteEnable = 1'b0;
        WriteData   = 16'hA5A5;
        for (int i = 0; i < 16; i++) begin
            a4 = 4'(i);
            setAddrs(a4, a4[2:0]);
            WriteAddr = a4;
            tick();
            checkValue("hold_rs", Rs, 16'(i));
            checkValue("hold_rsshort", RsShort, 16'(a4[2:0]));
        end

        // 5: write to R0 is a no-op, then async reset mid-cycle.
        WriteEnable = 1'b1;
        WriteAddr   = 4'd0;
        WriteData   = 16'hFFFF;
        setAddrs(4'd0, 3'd0);
        tick();
        checkValue("r0_rs", Rs, 16'h0000);
        setAddrs(4'd9, 3'd3);
        WriteEnable = 1'b0;
        #2;
        checkValue("pre_rst_rd", Rd, 16'd9);
        Reset = 1'b0;
        clearModel();
        #1;
        checkValue("async_rst_rd", Rd, 16'h0000);
        checkValue("async_rst_rt", Rt, 16'h0000);
        checkAll("async_rst");

        // Reset held across a write edge: reset wins.
        WriteEnable = 1'b1;
        WriteAddr   = 4'd3;
        WriteData   = 16'hBEEF;
        setAddrs(4'd3, 3'd3);
        tick();
        checkValue("rst_wins_rd", Rd, 16'h0000);
        #2;
        Reset = 1'b1;
        WriteEnable = 1'b0;
        tick();
        checkValue("rst_wins_after", Rd, 16'h0000);

        // 6: same-cycle write/read of R5.
        WriteEnable = 1'b1;
        WriteAddr   = 4'd5;
        WriteData   = 16'h0055;
        tick();
        WriteData   = 16'h1234;
        RsAddr      = 4'd5;
        #1;
        oldVal = 16'h0055;
`ifdef WRITE_BYPASS_EN
        checkValue("same_cycle_rs", Rs, 16'h1234);
`else
        checkValue("same_cycle_rs", Rs, oldVal);
`endif
        tick();
        WriteEnable = 1'b0;
        #1;
        checkValue("after_edge_rs", Rs, 16'h1234);

        // Randomized traffic against the model, checked before each edge.
        for (int n = 0; n < 400; n++) begin
            RsAddr      = 4'($urandom_range(0, 15));
            RdAddr      = 4'($urandom_range(0, 15));
            RsShortAddr = 3'($urandom_range(0, 7));
            RtAddr      = 3'($urandom_range(0, 7));
            RdShortAddr = 3'($urandom_range(0, 7));
            WriteAddr   = 4'($urandom_range(0, 15));
            WriteData   = 16'($urandom);
            WriteEnable = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) RsAddr = WriteAddr;
            if ($urandom_range(0, 39) == 0) begin
                Reset = 1'b0;
                clearModel();
                #1;
                checkAll("rand_rst");
                Reset = 1'b1;
            end
            #2;
            checkAll("rand");
            tick();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
